// File: rtl/mrv1_pkg.sv
// Shared types for the FU dispatch path: FU enumeration, op width and queue entry layout.
package mrv1_pkg;

  typedef enum logic [2:0] {
    FU_INT = 3'd0,
    FU_MEM = 3'd1,
    FU_MUL = 3'd2,
    FU_SYS = 3'd3,
    FU_DIV = 3'd4
  } mrv_fu_type_e;

  localparam int unsigned MRV_NUM_FU    = 5;
  localparam int unsigned MRV_FU_TYPE_W = 3;
  localparam int unsigned MRV_DATA_W    = 32;
  localparam int unsigned MRV_TAG_W     = 4;

  localparam int unsigned MRV_INT_OP_W  = 7;
  localparam int unsigned MRV_MEM_OP_W  = 4;
  localparam int unsigned MRV_MUL_OP_W  = 2;
  localparam int unsigned MRV_SYS_OP_W  = 3;
  localparam int unsigned MRV_DIV_OP_W  = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Op field must hold the widest per-FU op encoding.
  localparam int unsigned MRV_OP_W =
    max_u(max_u(max_u(MRV_INT_OP_W, MRV_MEM_OP_W), max_u(MRV_MUL_OP_W, MRV_SYS_OP_W)), MRV_DIV_OP_W);

  typedef struct packed {
    logic [MRV_FU_TYPE_W-1:0] fu_type;
    logic [MRV_OP_W-1:0]      op;
    logic [MRV_DATA_W-1:0]    opa;
    logic [MRV_DATA_W-1:0]    opb;
    logic [MRV_TAG_W-1:0]     tag;
  } mrv_dispatch_entry_t;

endpackage

// File: rtl/mrv_sync_fifo.sv
// Circular buffer of dispatch entries with occupancy count and synchronous flush.
module mrv_sync_fifo
  import mrv1_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  mrv_dispatch_entry_t       wdata_i,
  input  logic                      pop_i,
  output mrv_dispatch_entry_t       rdata_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  mrv_dispatch_entry_t mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      rd_ptr  <= wr_ptr;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + CNT_W'(1);
        2'b01:   count_o <= count_o - CNT_W'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/mrv_fu_dispatch_queue.sv
// In-order dispatch queue: buffers decoded ops and issues the head to its FU via valid/ready.
module mrv_fu_dispatch_queue
  import mrv1_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_FU    = MRV_NUM_FU,
  parameter int unsigned FU_TYPE_W = MRV_FU_TYPE_W,
  parameter int unsigned OP_W      = MRV_OP_W,
  parameter int unsigned DATA_W    = MRV_DATA_W,
  parameter int unsigned TAG_W     = MRV_TAG_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   enq_valid_i,
  output logic                   enq_ready_o,
  input  logic [FU_TYPE_W-1:0]   enq_fu_type_i,
  input  logic [OP_W-1:0]        enq_op_i,
  input  logic [DATA_W-1:0]      enq_opa_i,
  input  logic [DATA_W-1:0]      enq_opb_i,
  input  logic [TAG_W-1:0]       enq_tag_i,
  output logic [NUM_FU-1:0]      fu_valid_o,
  input  logic [NUM_FU-1:0]      fu_ready_i,
  output logic [OP_W-1:0]        fu_op_o,
  output logic [DATA_W-1:0]      fu_opa_o,
  output logic [DATA_W-1:0]      fu_opb_o,
  output logic [TAG_W-1:0]       fu_tag_o,
  output logic                   illegal_fu_o,
  output logic [TAG_W-1:0]       illegal_tag_o,
  output logic [$clog2(DEPTH):0] count_o
);

  mrv_dispatch_entry_t enq_entry;
  mrv_dispatch_entry_t head;
  logic                full;
  logic                empty;
  logic                head_live;
  logic                illegal_pop;
  logic                dispatch;
  logic                push;
  logic                pop;

  always_comb begin
    enq_entry.fu_type = enq_fu_type_i;
    enq_entry.op      = enq_op_i;
    enq_entry.opa     = enq_opa_i;
    enq_entry.opb     = enq_opb_i;
    enq_entry.tag     = enq_tag_i;
  end

  assign enq_ready_o = !full && !flush_i;
  assign push        = enq_valid_i && enq_ready_o;

  mrv_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (enq_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // Decode head FU type; out-of-range types are trapped and popped instead of issued.
  assign head_live   = !empty && !flush_i;
  assign illegal_pop = head_live && (head.fu_type >= FU_TYPE_W'(NUM_FU));

  always_comb begin
    fu_valid_o = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      fu_valid_o[k] = head_live && (head.fu_type == FU_TYPE_W'(k));
    end
  end

  assign dispatch = |(fu_valid_o & fu_ready_i);
  assign pop      = dispatch || illegal_pop;

  assign fu_op_o  = empty ? '0 : head.op;
  assign fu_opa_o = empty ? '0 : head.opa;
  assign fu_opb_o = empty ? '0 : head.opb;
  assign fu_tag_o = empty ? '0 : head.tag;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      illegal_fu_o  <= 1'b0;
      illegal_tag_o <= '0;
    end else begin
      illegal_fu_o <= illegal_pop;
      if (illegal_pop) illegal_tag_o <= head.tag;
    end
  end

endmodule

// File: tb/tb_mrv_fu_dispatch_queue.sv
// Directed self-checking bench for mrv_fu_dispatch_queue.
module tb_mrv_fu_dispatch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [2:0]  enq_fu_type;
  logic [6:0]  enq_op;
  logic [31:0] enq_opa;
  logic [31:0] enq_opb;
  logic [3:0]  enq_tag;
  logic [4:0]  fu_valid;
  logic [4:0]  fu_ready;
  logic [6:0]  fu_op;
  logic [31:0] fu_opa;
  logic [31:0] fu_opb;
  logic [3:0]  fu_tag;
  logic        illegal_fu;
  logic [3:0]  illegal_tag;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  mrv_fu_dispatch_queue dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .enq_valid_i   (enq_valid),
    .enq_ready_o   (enq_ready),
    .enq_fu_type_i (enq_fu_type),
    .enq_op_i      (enq_op),
    .enq_opa_i     (enq_opa),
    .enq_opb_i     (enq_opb),
    .enq_tag_i     (enq_tag),
    .fu_valid_o    (fu_valid),
    .fu_ready_i    (fu_ready),
    .fu_op_o       (fu_op),
    .fu_opa_o      (fu_opa),
    .fu_opb_o      (fu_opb),
    .fu_tag_o      (fu_tag),
    .illegal_fu_o  (illegal_fu),
    .illegal_tag_o (illegal_tag),
    .count_o       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [2:0] fu, input logic [6:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    enq_valid   = v;
    enq_fu_type = fu;
    enq_op      = op;
    enq_opa     = a;
    enq_opb     = b;
    enq_tag     = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fu_ready = '0;
    drive_enq(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (fu_valid !== 5'b0) begin n_err++; $display("FAIL reset_fu_valid got %b want 00000", fu_valid); end
    n_cmp++; if (illegal_fu !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b want 0", illegal_fu); end
    n_cmp++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL reset_enq_ready got %b want 1", enq_ready); end
    n_cmp++; if (fu_opa !== 32'd0 || fu_tag !== 4'd0) begin n_err++; $display("FAIL reset_data got opa=%0d tag=%0d want 0/0", fu_opa, fu_tag); end
    tick();
  endtask

  task automatic test_single();
    fu_ready = 5'b00001;
    drive_enq(1'b1, 3'd0, 7'b0011000, 32'd5, 32'd3, 4'd1);
    @(negedge clk);
    n_cmp++; if (fu_valid !== 5'b0) begin n_err++; $display("FAIL single_no_bypass got %b want 00000", fu_valid); end
    tick();
    drive_enq(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    n_cmp++; if (fu_valid !== 5'b00001) begin n_err++; $display("FAIL single_fu_valid got %b want 00001", fu_valid); end
    n_cmp++; if (fu_op !== 7'b0011000) begin n_err++; $display("FAIL single_op got %b want 0011000", fu_op); end
    n_cmp++; if (fu_opa !== 32'd5 || fu_opb !== 32'd3) begin n_err++; $display("FAIL single_operands got %0d/%0d want 5/3", fu_opa, fu_opb); end
    n_cmp++; if (fu_tag !== 4'd1) begin n_err++; $display("FAIL single_tag got %0d want 1", fu_tag); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count1 got %0d want 1", count); end
    tick();
    @(negedge clk);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count0 got %0d want 0", count); end
    n_cmp++; if (fu_valid !== 5'b0) begin n_err++; $display("FAIL single_drained got %b want 00000", fu_valid); end
    tick();
  endtask

  task automatic test_fill();
    logic [2:0] types [4];
    types[0] = 3'd0; types[1] = 3'd1; types[2] = 3'd2; types[3] = 3'd4;
    fu_ready = 5'b0;
    for (int i = 0; i < 4; i++) begin
      drive_enq(1'b1, types[i], 7'(i), 32'(100 + i), 32'(200 + i), 4'(i + 2));
      tick();
    end
    drive_enq(1'b1, 3'd0, 7'd0, 32'd0, 32'd0, 4'd15);
    @(negedge clk);
    n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL fill_enq_ready got %b want 0", enq_ready); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count); end
    tick();
    drive_enq(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
    fu_ready = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (fu_valid !== (5'b00001 << types[i]) || fu_tag !== 4'(i + 2) || fu_opa !== 32'(100 + i))
        begin n_err++; $display("FAIL drain_head%0d got valid=%b tag=%0d opa=%0d want valid=%b tag=%0d opa=%0d",
                                 i, fu_valid, fu_tag, fu_opa, 5'b00001 << types[i], i + 2, 100 + i); end
      n_cmp++; if (count !== 3'(4 - i)) begin n_err++; $display("FAIL drain_count%0d got %0d want %0d", i, count, 4 - i); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_final_count got %0d want 0", count); end
    tick();
  endtask

  task automatic test_stall();
    fu_ready = 5'b00001;
    drive_enq(1'b1, 3'd2, 7'd1, 32'hAA, 32'hBB, 4'd5);
    tick();
    drive_enq(1'b1, 3'd0, 7'd2, 32'hCC, 32'hDD, 4'd6);
    tick();
    drive_enq(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (fu_valid !== 5'b00100 || fu_tag !== 4'd5 || fu_opa !== 32'hAA || fu_op !== 7'd1 || count !== 3'd2)
        begin n_err++; $display("FAIL stall_cycle%0d got valid=%b tag=%0d opa=%h count=%0d want 00100/5/aa/2",
                                 c, fu_valid, fu_tag, fu_opa, count); end
      tick();
    end
    fu_ready = 5'b00101;
    tick();
    @(negedge clk);
    n_cmp++; if (fu_valid !== 5'b00001 || fu_tag !== 4'd6 || count !== 3'd1)
      begin n_err++; $display("FAIL stall_release got valid=%b tag=%0d count=%0d want 00001/6/1", fu_valid, fu_tag, count); end
    tick();
    @(negedge clk);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL stall_drained got %0d want 0", count); end
    tick();
  endtask

  task automatic test_illegal();
    fu_ready = 5'b11111;
    drive_enq(1'b1, 3'b110, 7'd3, 32'd1, 32'd2, 4'd9);
    tick();
    drive_enq(1'b1, 3'd0, 7'd4, 32'd11, 32'd12, 4'd10);
    @(negedge clk);
    n_cmp++; if (fu_valid !== 5'b0 || illegal_fu !== 1'b0)
      begin n_err++; $display("FAIL illegal_head got valid=%b pulse=%b want 00000/0", fu_valid, illegal_fu); end
    tick();
    drive_enq(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    n_cmp++; if (illegal_fu !== 1'b1 || illegal_tag !== 4'd9)
      begin n_err++; $display("FAIL illegal_pulse got pulse=%b tag=%0d want 1/9", illegal_fu, illegal_tag); end
    n_cmp++; if (fu_valid !== 5'b00001 || fu_tag !== 4'd10 || count !== 3'd1)
      begin n_err++; $display("FAIL illegal_next got valid=%b tag=%0d count=%0d want 00001/10/1", fu_valid, fu_tag, count); end
    tick();
    @(negedge clk);
    n_cmp++; if (illegal_fu !== 1'b0 || count !== 3'd0)
      begin n_err++; $display("FAIL illegal_one_cycle got pulse=%b count=%0d want 0/0", illegal_fu, count); end
    tick();
  endtask

  task automatic test_flush();
    fu_ready = 5'b0;
    for (int i = 0; i < 3; i++) begin
      drive_enq(1'b1, 3'd0, 7'd0, 32'(i), 32'd0, 4'(i + 1));
      tick();
    end
    fu_ready = 5'b00001;
    flush = 1'b1;
    drive_enq(1'b1, 3'd0, 7'd0, 32'd0, 32'd0, 4'd4);
    @(negedge clk);
    n_cmp++; if (fu_valid !== 5'b0 || enq_ready !== 1'b0 || count !== 3'd3)
      begin n_err++; $display("FAIL flush_cycle got valid=%b ready=%b count=%0d want 00000/0/3", fu_valid, enq_ready, count); end
    tick();
    flush = 1'b0;
    drive_enq(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    n_cmp++; if (count !== 3'd0 || fu_valid !== 5'b0)
      begin n_err++; $display("FAIL flush_after got count=%0d valid=%b want 0/00000", count, fu_valid); end
    drive_enq(1'b1, 3'd0, 7'd0, 32'd77, 32'd0, 4'd7);
    tick();
    drive_enq(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    n_cmp++; if (fu_valid !== 5'b00001 || fu_tag !== 4'd7 || fu_opa !== 32'd77)
      begin n_err++; $display("FAIL flush_reuse got valid=%b tag=%0d opa=%0d want 00001/7/77", fu_valid, fu_tag, fu_opa); end
    tick();
  endtask

  task automatic test_back_to_back();
    fu_ready = 5'b0;
    for (int i = 0; i < 2; i++) begin
      drive_enq(1'b1, 3'd0, 7'd0, 32'd0, 32'd0, 4'(i));
      tick();
    end
    fu_ready = 5'b00001;
    for (int i = 0; i < 9; i++) begin
      drive_enq(1'b1, 3'd0, 7'd0, 32'd0, 32'd0, 4'(i + 2));
      @(negedge clk);
      n_cmp++; if (count !== 3'd2 || fu_valid !== 5'b00001 || fu_tag !== 4'(i))
        begin n_err++; $display("FAIL b2b_cycle%0d got count=%0d valid=%b tag=%0d want 2/00001/%0d", i, count, fu_valid, fu_tag, i); end
      tick();
    end
    drive_enq(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
    for (int i = 9; i < 11; i++) begin
      @(negedge clk);
      n_cmp++; if (fu_tag !== 4'(i) || fu_valid !== 5'b00001)
        begin n_err++; $display("FAIL b2b_drain%0d got tag=%0d valid=%b want %0d/00001", i, fu_tag, fu_valid, i); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_empty got %0d want 0", count); end
    tick();
  endtask

  task automatic test_reset_mid();
    fu_ready = 5'b0;
    for (int i = 0; i < 2; i++) begin
      drive_enq(1'b1, 3'd1, 7'd0, 32'd0, 32'd0, 4'(i));
      tick();
    end
    drive_enq(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 4'd0);
    rst = 1'b1;
    #1;
    n_cmp++; if (count !== 3'd0 || fu_valid !== 5'b0)
      begin n_err++; $display("FAIL reset_mid got count=%0d valid=%b want 0/00000", count, fu_valid); end
    tick();
    rst = 1'b0;
    fu_ready = 5'b11111;
    @(negedge clk);
    n_cmp++; if (count !== 3'd0 || fu_valid !== 5'b0 || illegal_fu !== 1'b0)
      begin n_err++; $display("FAIL reset_mid_release got count=%0d valid=%b pulse=%b want 0/00000/0", count, fu_valid, illegal_fu); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stall();
    test_illegal();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
